// File: rtl/store_drain.sv
// Store-queue drain: retires ROB-committed stores from the queue head to the
// data-memory write port in program order, popping each entry once its write is acked.
module store_drain #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int CNT_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                sq_empty,
   input  logic [ADDR_W-1:0]   sq_addr,
   input  logic [DATA_W-1:0]   sq_wdata,
   input  logic [DATA_W/8-1:0] sq_wmask,
   output logic                sq_dequeue,
   input  logic                commit_store,
   output logic [ADDR_W-1:0]   dmem_addr,
   output logic [DATA_W/8-1:0] dmem_wmask,
   output logic [DATA_W-1:0]   dmem_wdata,
   input  logic                dmem_resp,
   output logic [CNT_W-1:0]    committed_cnt,
   output logic                drain_busy,
   output logic                cnt_overflow
);

   localparam int MASK_W = DATA_W / 8;
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [ADDR_W-1:0] WORD_ALIGN = {{(ADDR_W-2){1'b1}}, 2'b00};

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DONE
   } state_t;

   state_t state;
   state_t next_state;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [MASK_W-1:0] wmask_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q;
   logic              latch_en;

   // A head entry may only be taken once the ROB has committed at least one store.
   assign latch_en = (state == IDLE) && (cnt_q != '0) && !sq_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (latch_en) begin
               next_state = (sq_wmask != '0) ? REQ : DONE;
            end
         end
         REQ: begin
            if (dmem_resp) begin
               next_state = DONE;
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Latched copy keeps the request stable even if the queue head moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wmask_q <= '0;
      end else if (latch_en) begin
         addr_q  <= sq_addr;
         wdata_q <= sq_wdata;
         wmask_q <= sq_wmask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         case ({commit_store, state == DONE})
            2'b10: begin
               if (cnt_q == CNT_MAX) begin
                  ovf_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            2'b01: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   always_comb begin
      dmem_addr  = '0;
      dmem_wmask = '0;
      dmem_wdata = '0;
      sq_dequeue = 1'b0;
      case (state)
         REQ: begin
            dmem_addr  = addr_q & WORD_ALIGN;
            dmem_wmask = wmask_q;
            dmem_wdata = wdata_q;
         end
         DONE:    sq_dequeue = 1'b1;
         default: sq_dequeue = 1'b0;
      endcase
   end

   assign drain_busy    = (state != IDLE);
   assign committed_cnt = cnt_q;
   assign cnt_overflow  = ovf_q;

endmodule

// File: tb/tb_store_drain.sv
// Bench for store_drain: directed scenarios plus a randomized phase, all judged
// against a queue-based model of the store queue, commit count and write order.
module tb_store_drain;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 4;
   localparam int MASK_W = DATA_W / 8;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              sq_empty;
   logic [ADDR_W-1:0] sq_addr;
   logic [DATA_W-1:0] sq_wdata;
   logic [MASK_W-1:0] sq_wmask;
   logic              sq_dequeue;
   logic              commit_store;
   logic [ADDR_W-1:0] dmem_addr;
   logic [MASK_W-1:0] dmem_wmask;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_resp;
   logic [CNT_W-1:0]  committed_cnt;
   logic              drain_busy;
   logic              cnt_overflow;

   always #5 clk = ~clk;

   store_drain #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sq_empty     (sq_empty),
      .sq_addr      (sq_addr),
      .sq_wdata     (sq_wdata),
      .sq_wmask     (sq_wmask),
      .sq_dequeue   (sq_dequeue),
      .commit_store (commit_store),
      .dmem_addr    (dmem_addr),
      .dmem_wmask   (dmem_wmask),
      .dmem_wdata   (dmem_wdata),
      .dmem_resp    (dmem_resp),
      .committed_cnt(committed_cnt),
      .drain_busy   (drain_busy),
      .cnt_overflow (cnt_overflow)
   );

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic [MASK_W-1:0] mask;
   } entry_t;

   entry_t sq_q[$];
   int     deq_times[$];
   int     checks = 0;
   int     failures = 0;
   int     cnt_model = 0;
   bit     ovf_model = 1'b0;
   bit     wrote = 1'b0;
   int     cycle = 0;
   int     writes = 0;
   int     resp_mode = 0;
   bit     hold_head = 1'b0;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic driveHead();
      if (!hold_head) begin
         if (sq_q.size() == 0) begin
            sq_empty = 1'b1;
            sq_addr  = '0;
            sq_wdata = '0;
            sq_wmask = '0;
         end else begin
            sq_empty = 1'b0;
            sq_addr  = sq_q[0].addr;
            sq_wdata = sq_q[0].data;
            sq_wmask = sq_q[0].mask;
         end
      end
   endtask

   task automatic pushEntry(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input logic [MASK_W-1:0] m);
      entry_t e;
      e.addr = a;
      e.data = d;
      e.mask = m;
      sq_q.push_back(e);
      driveHead();
   endtask

   // One clock of the model: account for the write/pop seen this cycle, advance,
   // then update the commit count and check request contents and latency.
   task automatic stepCycle();
      bit               deq;
      bit               hs;
      bit               inc;
      bit               elig;
      logic [MASK_W-1:0] head_mask;
      deq       = sq_dequeue;
      hs        = (dmem_wmask != '0) && dmem_resp;
      inc       = commit_store;
      elig      = !drain_busy && (cnt_model != 0) && !sq_empty;
      head_mask = sq_wmask;
      checkOutput("committed_cnt", 32'(committed_cnt), 32'(cnt_model));
      if (hs) begin
         writes++;
         checkOutput("write_queue_nonempty", 32'(sq_q.size() != 0), 32'd1);
         checkOutput("write_not_repeated", 32'(wrote), 32'd0);
         wrote = 1'b1;
      end
      if (deq) begin
         checkOutput("dequeue_queue_nonempty", 32'(sq_q.size() != 0), 32'd1);
         checkOutput("dequeue_committed", 32'(cnt_model > 0), 32'd1);
         if (sq_q.size() != 0) begin
            checkOutput("dequeue_after_write", 32'(wrote), 32'(sq_q[0].mask != '0));
            void'(sq_q.pop_front());
         end
         deq_times.push_back(cycle);
         wrote = 1'b0;
      end
      @(posedge clk);
      #1;
      cycle++;
      if (inc && !deq) begin
         if (cnt_model == (1 << CNT_W) - 1) ovf_model = 1'b1;
         else cnt_model++;
      end else if (deq && !inc) begin
         cnt_model--;
      end
      checkOutput("cnt_overflow", 32'(cnt_overflow), 32'(ovf_model));
      if (elig) begin
         checkOutput("latency_busy", 32'(drain_busy), 32'd1);
         if (head_mask != '0) checkOutput("latency_wmask", 32'(dmem_wmask), 32'(head_mask));
         else checkOutput("zero_mask_dequeue", 32'(sq_dequeue), 32'd1);
      end
      if (dmem_wmask != '0 && sq_q.size() != 0) begin
         checkOutput("req_addr", dmem_addr, sq_q[0].addr & 32'hFFFF_FFFC);
         checkOutput("req_wdata", dmem_wdata, sq_q[0].data);
         checkOutput("req_wmask", 32'(dmem_wmask), 32'(sq_q[0].mask));
      end
      case (resp_mode)
         1: dmem_resp = (dmem_wmask != '0);
         2: dmem_resp = ($urandom_range(0, 2) == 0);
         default: dmem_resp = dmem_resp;
      endcase
      driveHead();
   endtask

   task automatic applyReset();
      rst_n        = 1'b0;
      commit_store = 1'b0;
      dmem_resp    = 1'b0;
      #1;
      checkOutput("rst_dmem_addr", dmem_addr, 32'd0);
      checkOutput("rst_dmem_wmask", 32'(dmem_wmask), 32'd0);
      checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
      checkOutput("rst_sq_dequeue", 32'(sq_dequeue), 32'd0);
      checkOutput("rst_drain_busy", 32'(drain_busy), 32'd0);
      checkOutput("rst_committed_cnt", 32'(committed_cnt), 32'd0);
      checkOutput("rst_cnt_overflow", 32'(cnt_overflow), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      cnt_model = 0;
      ovf_model = 1'b0;
      wrote     = 1'b0;
      driveHead();
   endtask

   task automatic waitDrain(input int max_cycles);
      int n = 0;
      while ((cnt_model != 0 || drain_busy) && n < max_cycles) begin
         stepCycle();
         n++;
      end
      checkOutput("drain_completes", 32'(cnt_model == 0 && !drain_busy), 32'd1);
   endtask

   task automatic applyStimulus();
      if (sq_q.size() < 6 && $urandom_range(0, 3) == 0)
         pushEntry($urandom, $urandom, 4'($urandom_range(0, 15)));
      commit_store = (sq_q.size() > cnt_model) && ($urandom_range(0, 1) == 1);
      stepCycle();
   endtask

   initial begin
      int wr_before;
      sq_empty     = 1'b1;
      sq_addr      = '0;
      sq_wdata     = '0;
      sq_wmask     = '0;
      commit_store = 1'b0;
      dmem_resp    = 1'b0;
      applyReset();

      // Idle with a visible head but nothing committed.
      pushEntry(32'h0000_1006, 32'h00AB_0000, 4'b0100);
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         checkOutput("idle_wmask", 32'(dmem_wmask), 32'd0);
      end

      // Single store with a 5-cycle response and a head change mid-request.
      commit_store = 1'b1;
      stepCycle();
      commit_store = 1'b0;
      checkOutput("single_cnt_one", 32'(committed_cnt), 32'd1);
      checkOutput("single_idle_busy", 32'(drain_busy), 32'd0);
      stepCycle();
      for (int i = 0; i < 5; i++) begin
         checkOutput("single_addr", dmem_addr, 32'h0000_1004);
         checkOutput("single_wmask", 32'(dmem_wmask), 32'h4);
         checkOutput("single_wdata", dmem_wdata, 32'h00AB_0000);
         checkOutput("single_no_deq", 32'(sq_dequeue), 32'd0);
         if (i == 1) begin
            hold_head = 1'b1;
            sq_addr   = 32'hDEAD_BEE0;
            sq_wdata  = 32'h1234_5678;
            sq_wmask  = 4'hF;
         end
         dmem_resp = (i == 4);
         stepCycle();
      end
      checkOutput("single_deq_pulse", 32'(sq_dequeue), 32'd1);
      checkOutput("single_wmask_off", 32'(dmem_wmask), 32'd0);
      dmem_resp = 1'b0;
      hold_head = 1'b0;
      driveHead();
      stepCycle();
      checkOutput("single_deq_once", 32'(sq_dequeue), 32'd0);
      checkOutput("single_cnt_zero", 32'(committed_cnt), 32'd0);

      // Back-to-back drain with same-cycle responses.
      pushEntry(32'h0000_2000, 32'h1111_1111, 4'b1111);
      pushEntry(32'h0000_2005, 32'h0000_2200, 4'b0010);
      pushEntry(32'h0000_200B, 32'h3300_0000, 4'b1000);
      resp_mode = 1;
      deq_times.delete();
      commit_store = 1'b1;
      repeat (3) stepCycle();
      commit_store = 1'b0;
      waitDrain(100);
      checkOutput("b2b_dequeues", 32'(deq_times.size()), 32'd3);
      if (deq_times.size() == 3) begin
         checkOutput("b2b_spacing_1", 32'(deq_times[1] - deq_times[0]), 32'd3);
         checkOutput("b2b_spacing_2", 32'(deq_times[2] - deq_times[1]), 32'd3);
      end

      // Commit arriving in the DONE cycle while count is 2.
      pushEntry(32'h0000_3000, 32'hAAAA_0001, 4'b0011);
      pushEntry(32'h0000_3004, 32'hAAAA_0002, 4'b1100);
      pushEntry(32'h0000_3008, 32'hAAAA_0003, 4'b0001);
      commit_store = 1'b1;
      repeat (2) stepCycle();
      commit_store = 1'b0;
      stepCycle();
      checkOutput("simul_in_done", 32'(sq_dequeue), 32'd1);
      checkOutput("simul_cnt_before", 32'(committed_cnt), 32'd2);
      commit_store = 1'b1;
      stepCycle();
      commit_store = 1'b0;
      checkOutput("simul_cnt_after", 32'(committed_cnt), 32'd2);
      waitDrain(100);

      // Saturation with an empty queue.
      resp_mode = 0;
      dmem_resp = 1'b0;
      commit_store = 1'b1;
      repeat (15) stepCycle();
      checkOutput("sat_cnt_15", 32'(committed_cnt), 32'd15);
      checkOutput("sat_no_ovf", 32'(cnt_overflow), 32'd0);
      stepCycle();
      checkOutput("sat_cnt_holds", 32'(committed_cnt), 32'd15);
      checkOutput("sat_ovf_set", 32'(cnt_overflow), 32'd1);
      commit_store = 1'b0;
      repeat (3) stepCycle();
      checkOutput("sat_ovf_sticky", 32'(cnt_overflow), 32'd1);
      applyReset();

      // Reset in the middle of a request abandons it without a pop.
      pushEntry(32'h0000_4002, 32'h0055_0000, 4'b0100);
      commit_store = 1'b1;
      stepCycle();
      commit_store = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("midrst_in_req", 32'(dmem_wmask), 32'h4);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_wmask", 32'(dmem_wmask), 32'd0);
      checkOutput("midrst_no_deq", 32'(sq_dequeue), 32'd0);
      applyReset();
      wr_before = writes;
      commit_store = 1'b1;
      stepCycle();
      commit_store = 1'b0;
      resp_mode = 1;
      waitDrain(50);
      checkOutput("midrst_rewrite_once", 32'(writes - wr_before), 32'd1);
      checkOutput("midrst_queue_empty", 32'(sq_q.size()), 32'd0);

      // Randomized traffic with random (sometimes stray) responses.
      resp_mode = 2;
      wr_before = writes;
      for (int i = 0; i < 3000; i++) applyStimulus();
      commit_store = 1'b0;
      resp_mode = 1;
      waitDrain(300);
      checkOutput("random_made_writes", 32'(writes > wr_before), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
